mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//   Memory-side responder for CPU load/store traffic. The CPU's MAR/MDR datapath drives
//   address, write data and write enable into it. Requests use a valid/ready handshake
//   and responses use a valid/ready handshake. The block holds a word-addressed RAM
//   array and inserts a programmable number of wait states before each response.
//   Only one transaction is outstanding at a time.
// PARAMETERS
//   ADDR_WIDTH   8    request address width (matches MAR)
//   DATA_WIDTH   8    data word width (matches MDR)
//   DEPTH        256  number of words; power of two, 2 <= DEPTH <= 2**ADDR_WIDTH
//   WAIT_STATES  0    extra cycles between accept and response, 0..15
// PORTS
//   clk         in   1           rising-edge clock
//   reset       in   1           synchronous, active-high reset
//   req_valid   in   1           request present
//   req_ready   out  1           responder can accept; high only in IDLE
//   req_we      in   1           1 = write, 0 = read
//   req_addr    in   ADDR_WIDTH  word address
//   req_wdata   in   DATA_WIDTH  write data
//   rsp_valid   out  1           response present
//   rsp_ready   in   1           requester takes response
//   rsp_rdata   out  DATA_WIDTH  read data; on a write, the value now stored
//   rsp_err     out  1           address error (always 0 unless MEM_ERR_EN)
// BEHAVIOUR
//   - Reset values: state=IDLE, wait counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
//     The RAM array is not cleared.
//   - FSM states are IDLE, WAIT and RESP. req_ready = (state==IDLE), combinational from state.
//   - IDLE: on req_valid && req_ready at edge T:
//       - latch we, addr and wdata;
//       - load the counter with WAIT_STATES;
//       - go to WAIT.
//   - WAIT: if counter != 0, decrement it. If counter == 0, perform the access at this edge
//     and go to RESP:
//       - read: rsp_rdata <= mem[idx];
//       - write: mem[idx] <= wdata and rsp_rdata <= wdata.
//   - Latency: rsp_valid rises WAIT_STATES+1 cycles after the accept edge.
//     With WAIT_STATES=0, rsp_valid is high in cycle T+1.
//   - RESP: rsp_valid=1; rsp_rdata and rsp_err stay stable until the handshake.
//     On rsp_ready, go to IDLE; rsp_valid falls the next cycle.
//   - Back-to-back: a new request is accepted no earlier than the cycle after the response
//     handshake. req_valid held during WAIT or RESP is ignored, not dropped; the requester
//     keeps it asserted.
//   - Index: idx = req_addr[log2(DEPTH)-1:0]. Address arithmetic is unsigned, with no
//     wrap logic beyond this truncation.
//   - Read-after-write to the same address returns the written value; there is no
//     stale-data window.
//   - Reset mid-operation has priority over every other event:
//       - a write still in WAIT is abandoned and mem is unchanged;
//       - a write already committed (now in RESP) stays in the array;
//       - the pending response is discarded and rsp_valid=0 the next cycle.
//   - rsp_rdata holds its last value in IDLE and WAIT.
// CONFIGURATION
//   MEM_ERR_EN defined:
//     - req_addr >= DEPTH sets rsp_err=1 with the response;
//     - no array write, rsp_rdata=0;
//     - latency is unchanged;
//     - rsp_err is cleared on the next accepted in-range request or on reset.
//   MEM_ERR_EN undefined:
//     - out-of-range addresses alias through idx truncation;
//     - rsp_err is tied to 0.
// TESTING
//   1. Reset with rsp_ready=1: assert reset 2 cycles -> rsp_valid=0, rsp_rdata=0, req_ready=1.
//   2. WAIT_STATES=0: write addr 0x10 data 0xA5, then read 0x10 -> rsp_valid 1 cycle after
//      each accept; read returns 0xA5.
//   3. WAIT_STATES=3: read addr 0x20 (preloaded 0x3C) -> rsp_valid rises exactly 4 cycles
//      after accept; req_ready=0 throughout.
//   4. Backpressure: hold rsp_ready=0 for 5 cycles during RESP -> rsp_valid and rsp_rdata
//      stay stable; a second req_valid is not accepted until after the handshake.
//   5. Reset in WAIT (WAIT_STATES=2) during write 0x55 to 0x30 (old 0x11) -> re-read
//      after reset returns 0x11.
//   6. DEPTH=128: MEM_ERR_EN on, write 0x80 -> rsp_err=1, mem[0] unchanged.
//      MEM_ERR_EN off -> mem[0] is written.

Source files
------------

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Brief    : Word-addressed RAM responder for CPU load/store requests.
//            Uses valid/ready on both the request and response sides, and
//            inserts programmable wait states before each response.
//            Optional macro MEM_ERR_EN flags out-of-range addresses.
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    localparam int         c_IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] c_WAIT_LOAD = 4'(WAIT_STATES);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]            r_state;
    logic [3:0]            r_cnt;
    logic                  r_we;
    logic                  r_oor;
    logic [c_IDX_W-1:0]    r_idx;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic w_oor;
    logic w_access;
    logic w_mem_we;
    logic w_unused_addr;

`ifdef MEM_ERR_EN
    logic r_rsp_err;
    assign w_oor   = |(req_addr >> c_IDX_W);
    assign rsp_err = r_rsp_err;
`else
    assign w_oor   = 1'b0;
    assign rsp_err = 1'b0;
`endif

    assign req_ready     = (r_state == c_IDLE);
    assign rsp_valid     = r_rsp_valid;
    assign rsp_rdata     = r_rsp_rdata;
    assign w_unused_addr = ^req_addr;

    // The access edge is the last WAIT cycle; reset at that same edge wins.
    assign w_access = (r_state == c_WAIT) && (r_cnt == 4'd0);
    assign w_mem_we = w_access && r_we && !r_oor && !reset;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_cnt       <= 4'd0;
            r_we        <= 1'b0;
            r_oor       <= 1'b0;
            r_idx       <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
`ifdef MEM_ERR_EN
            r_rsp_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_idx   <= req_addr[c_IDX_W-1:0];
                        r_wdata <= req_wdata;
                        r_oor   <= w_oor;
                        r_cnt   <= c_WAIT_LOAD;
                        r_state <= c_WAIT;
`ifdef MEM_ERR_EN
                        if (!w_oor) begin
                            r_rsp_err <= 1'b0;
                        end
`endif
                    end
                end
                c_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_state     <= c_RESP;
                        r_rsp_valid <= 1'b1;
                        if (r_oor) begin
                            r_rsp_rdata <= '0;
`ifdef MEM_ERR_EN
                            r_rsp_err   <= 1'b1;
`endif
                        end else if (r_we) begin
                            r_rsp_rdata <= r_wdata;
                        end else begin
                            r_rsp_rdata <= r_mem[r_idx];
                        end
                    end
                end
                c_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= c_IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= c_IDLE;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_responder
// Brief    : Randomized self-checking bench for mem_responder; three instances
//            with different depth / wait-state settings against an array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    localparam int c_N = 3;

`ifdef MEM_ERR_EN
    localparam bit c_ERR_EN = 1'b1;
`else
    localparam bit c_ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       r_reset     [c_N];
    logic       r_req_valid [c_N];
    logic       r_req_we    [c_N];
    logic [7:0] r_req_addr  [c_N];
    logic [7:0] r_req_wdata [c_N];
    logic       r_rsp_ready [c_N];
    logic       w_req_ready [c_N];
    logic       w_rsp_valid [c_N];
    logic [7:0] w_rsp_rdata [c_N];
    logic       w_rsp_err   [c_N];

    logic [7:0] model_mem   [c_N][256];
    bit         model_known [c_N][256];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < c_N; g++) begin : g_dut
            localparam int c_WS    = (g == 0) ? 0 : ((g == 1) ? 3 : 2);
            localparam int c_DEPTH = (g == 1) ? 128 : 256;
            mem_responder #(
                .ADDR_WIDTH (8),
                .DATA_WIDTH (8),
                .DEPTH      (c_DEPTH),
                .WAIT_STATES(c_WS)
            ) u_dut (
                .clk      (clk),
                .reset    (r_reset[g]),
                .req_valid(r_req_valid[g]),
                .req_ready(w_req_ready[g]),
                .req_we   (r_req_we[g]),
                .req_addr (r_req_addr[g]),
                .req_wdata(r_req_wdata[g]),
                .rsp_valid(w_rsp_valid[g]),
                .rsp_ready(r_rsp_ready[g]),
                .rsp_rdata(w_rsp_rdata[g]),
                .rsp_err  (w_rsp_err[g])
            );
        end
    endgenerate

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 3 : 2);
    endfunction

    function automatic int depth_of(input int d);
        return (d == 1) ? 128 : 256;
    endfunction

    task automatic check_eq(input string tag, input int d, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d got=%0h exp=%0h at %0t", tag, d, got, exp, $time);
        end
    endtask

    function automatic bit is_oor(input int d, input logic [7:0] addr);
        return c_ERR_EN && (int'(addr) >= depth_of(d));
    endfunction

    task automatic model_write(input int d, input logic [7:0] addr, input logic [7:0] wdata);
        int idx;
        idx = int'(addr) % depth_of(d);
        if (!is_oor(d, addr)) begin
            model_mem[d][idx]   = wdata;
            model_known[d][idx] = 1'b1;
        end
    endtask

    // Full transaction; during 'hold' cycles of backpressure a second request is
    // presented and must not be taken.
    task automatic run_txn(input int d, input bit we, input logic [7:0] addr,
                           input logic [7:0] wdata, input int hold);
        int         cyc;
        int         idx;
        logic [7:0] exp_data;
        bit         exp_err;
        bit         known;
        idx = int'(addr) % depth_of(d);
        if (is_oor(d, addr)) begin
            exp_data = 8'h00; exp_err = 1'b1; known = 1'b1;
        end else if (we) begin
            exp_data = wdata; exp_err = 1'b0; known = 1'b1;
        end else begin
            exp_data = model_mem[d][idx]; exp_err = 1'b0; known = model_known[d][idx];
        end

        r_req_valid[d] = 1'b1;
        r_req_we[d]    = we;
        r_req_addr[d]  = addr;
        r_req_wdata[d] = wdata;
        r_rsp_ready[d] = 1'b0;
        cyc = 0;
        while (!w_req_ready[d] && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("req_ready_idle", d, 32'(w_req_ready[d]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        r_req_valid[d] = 1'b0;
        cyc = 0;
        while (!w_rsp_valid[d] && cyc < 50) begin
            check_eq("req_ready_busy", d, 32'(w_req_ready[d]), 32'd0);
            @(negedge clk);
            cyc++;
        end
        check_eq("latency", d, 32'(cyc), 32'(ws_of(d) + 1));
        check_eq("req_ready_resp", d, 32'(w_req_ready[d]), 32'd0);
        if (known) check_eq("rdata", d, 32'(w_rsp_rdata[d]), 32'(exp_data));
        check_eq("err", d, 32'(w_rsp_err[d]), 32'(exp_err));

        if (hold > 0) begin
            r_req_valid[d] = 1'b1;
            r_req_we[d]    = 1'b0;
            r_req_addr[d]  = addr ^ 8'h01;
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_eq("hold_valid", d, 32'(w_rsp_valid[d]), 32'd1);
            check_eq("hold_ready", d, 32'(w_req_ready[d]), 32'd0);
            if (known) check_eq("hold_rdata", d, 32'(w_rsp_rdata[d]), 32'(exp_data));
            check_eq("hold_err", d, 32'(w_rsp_err[d]), 32'(exp_err));
        end
        r_rsp_ready[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        r_rsp_ready[d] = 1'b0;
        r_req_valid[d] = 1'b0;
        check_eq("valid_after_hs", d, 32'(w_rsp_valid[d]), 32'd0);
        check_eq("ready_after_hs", d, 32'(w_req_ready[d]), 32'd1);
        if (known) check_eq("rdata_idle", d, 32'(w_rsp_rdata[d]), 32'(exp_data));
        if (we) model_write(d, addr, wdata);
    endtask

    // Accept a request, then reset so it is sampled n+1 edges after the accept.
    task automatic abort_txn(input int d, input bit we, input logic [7:0] addr,
                             input logic [7:0] wdata, input int n);
        r_req_valid[d] = 1'b1;
        r_req_we[d]    = we;
        r_req_addr[d]  = addr;
        r_req_wdata[d] = wdata;
        r_rsp_ready[d] = 1'b0;
        check_eq("abort_ready", d, 32'(w_req_ready[d]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        r_req_valid[d] = 1'b0;
        for (int k = 0; k < n; k++) @(negedge clk);
        r_reset[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        r_reset[d] = 1'b0;
        check_eq("abort_valid", d, 32'(w_rsp_valid[d]), 32'd0);
        check_eq("abort_req_ready", d, 32'(w_req_ready[d]), 32'd1);
        check_eq("abort_rdata", d, 32'(w_rsp_rdata[d]), 32'd0);
        check_eq("abort_err", d, 32'(w_rsp_err[d]), 32'd0);
        if (we && n >= ws_of(d) + 1) model_write(d, addr, wdata);
    endtask

    initial begin
        logic [7:0] a;
        for (int d = 0; d < c_N; d++) begin
            r_reset[d]     = 1'b1;
            r_req_valid[d] = 1'b0;
            r_req_we[d]    = 1'b0;
            r_req_addr[d]  = 8'h00;
            r_req_wdata[d] = 8'h00;
            r_rsp_ready[d] = 1'b1;
            for (int i = 0; i < 256; i++) begin
                model_mem[d][i]   = 8'h00;
                model_known[d][i] = 1'b0;
            end
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < c_N; d++) begin
            r_reset[d] = 1'b0;
            check_eq("rst_valid", d, 32'(w_rsp_valid[d]), 32'd0);
            check_eq("rst_rdata", d, 32'(w_rsp_rdata[d]), 32'd0);
            check_eq("rst_ready", d, 32'(w_req_ready[d]), 32'd1);
            check_eq("rst_err", d, 32'(w_rsp_err[d]), 32'd0);
            r_rsp_ready[d] = 1'b0;
        end

        // Zero wait states, then three wait states with a preloaded word
        run_txn(0, 1'b1, 8'h10, 8'hA5, 0);
        run_txn(0, 1'b0, 8'h10, 8'h00, 0);
        run_txn(1, 1'b1, 8'h20, 8'h3C, 0);
        run_txn(1, 1'b0, 8'h20, 8'h00, 0);

        // Long backpressure with a competing request held high
        run_txn(0, 1'b0, 8'h10, 8'h00, 5);
        run_txn(1, 1'b1, 8'h21, 8'h5E, 5);

        // Reset during WAIT, at the access edge, and after commit
        run_txn(2, 1'b1, 8'h30, 8'h11, 0);
        abort_txn(2, 1'b1, 8'h30, 8'h55, 1);
        run_txn(2, 1'b0, 8'h30, 8'h00, 0);
        run_txn(2, 1'b1, 8'h32, 8'h22, 0);
        abort_txn(2, 1'b1, 8'h32, 8'h66, 2);
        run_txn(2, 1'b0, 8'h32, 8'h00, 0);
        abort_txn(2, 1'b1, 8'h31, 8'h77, 3);
        run_txn(2, 1'b0, 8'h31, 8'h00, 0);

        // Address beyond DEPTH=128: error or alias onto word 0
        run_txn(1, 1'b1, 8'h00, 8'h99, 0);
        run_txn(1, 1'b1, 8'h80, 8'h42, 0);
        run_txn(1, 1'b0, 8'h00, 8'h00, 0);
        run_txn(1, 1'b0, 8'h80, 8'h00, 1);
        run_txn(1, 1'b0, 8'h00, 8'h00, 0);

        for (int d = 0; d < c_N; d++) begin
            for (int t = 0; t < 60; t++) begin
                a = 8'($urandom_range(0, 15));
                if ($urandom_range(0, 1) == 1) a = a | 8'h80;
                if ($urandom_range(0, 7) == 0) a = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 9) == 0)
                    abort_txn(d, 1'($urandom_range(0, 1)), a, 8'($urandom),
                              int'($urandom_range(0, ws_of(d) + 2)));
                else
                    run_txn(d, 1'($urandom_range(0, 1)), a, 8'($urandom),
                            int'($urandom_range(0, 3)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
